// File: rtl/router_pkt_tx_if.sv
// Bundle of the request, upstream byte and router-side signals of router_pkt_tx.
// The master modport is the driving environment; the slave modport is the block.
interface router_pkt_tx_if;
   logic       start;
   logic [1:0] dest;
   logic [5:0] len;
   logic       corrupt;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       busy;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       tx_active;
   logic       tx_done;
   logic       cfg_err;

   modport master (
      output start, dest, len, corrupt, in_data, in_valid, busy,
      input  in_ready, pkt_valid, data_out, tx_active, tx_done, cfg_err
   );

   modport slave (
      input  start, dest, len, corrupt, in_data, in_valid, busy,
      output in_ready, pkt_valid, data_out, tx_active, tx_done, cfg_err
   );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload of len bytes, then sends header
// {len,dest}, the payload and a parity byte to a router that may stall via busy,
// followed by GAP idle cycles and a tx_done pulse.
module router_pkt_tx #(
   parameter int unsigned GAP = 3
) (
   input logic           clock,
   input logic           resetn,
   router_pkt_tx_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_HDR, S_PLD, S_PAR, S_GAP} state_t;

   // The shared counter also times the gap, so GAP must fit in its 6 bits.
   localparam logic [5:0] GAP_LAST = 6'(GAP - 1);

   state_t     state, state_n;
   logic [5:0] cnt, cnt_n;
   logic [5:0] len_q, len_n;
   logic [1:0] dest_q, dest_n;
   logic       corrupt_q, corrupt_n;
   logic [7:0] par_q, par_n;
   logic       cfg_err_q, cfg_err_n;
   logic       tx_done_q, tx_done_n;
   logic       buf_we;
   logic [7:0] mem [64];

   // Next-state, counter, latch and parity logic; cnt is the fill write index,
   // then the payload read index, then the gap cycle counter.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      len_n     = len_q;
      dest_n    = dest_q;
      corrupt_n = corrupt_q;
      par_n     = par_q;
      cfg_err_n = 1'b0;
      tx_done_n = 1'b0;
      buf_we    = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.dest == 2'd3 || bus.len == 6'd0) begin
                  cfg_err_n = 1'b1;
               end else begin
                  len_n     = bus.len;
                  dest_n    = bus.dest;
                  corrupt_n = bus.corrupt;
                  cnt_n     = '0;
                  par_n     = {bus.len, bus.dest};
                  state_n   = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (bus.in_valid) begin
               buf_we = 1'b1;
               par_n  = par_q ^ bus.in_data;
               if (cnt == len_q - 6'd1) begin
                  cnt_n   = '0;
                  state_n = S_HDR;
               end else begin
                  cnt_n = cnt + 6'd1;
               end
            end
         end
         S_HDR: begin
            if (!bus.busy) state_n = S_PLD;
         end
         S_PLD: begin
            if (!bus.busy) begin
               if (cnt == len_q - 6'd1) begin
                  cnt_n   = '0;
                  state_n = S_PAR;
               end else begin
                  cnt_n = cnt + 6'd1;
               end
            end
         end
         S_PAR: begin
            if (!bus.busy) begin
               cnt_n   = '0;
               state_n = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_n     = '0;
               tx_done_n = 1'b1;
               state_n   = S_IDLE;
            end else begin
               cnt_n = cnt + 6'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State and control registers, cleared asynchronously.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         cnt       <= '0;
         len_q     <= '0;
         dest_q    <= '0;
         corrupt_q <= 1'b0;
         par_q     <= '0;
         cfg_err_q <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         len_q     <= len_n;
         dest_q    <= dest_n;
         corrupt_q <= corrupt_n;
         par_q     <= par_n;
         cfg_err_q <= cfg_err_n;
         tx_done_q <= tx_done_n;
      end
   end

   // Payload buffer; contents are don't-care across reset.
   always_ff @(posedge clock) begin
      if (buf_we) mem[cnt] <= bus.in_data;
   end

   // Output decode from registered state only, so busy/start/in_* never reach outputs.
   always_comb begin
      bus.data_out = '0;
      case (state)
         S_HDR:   bus.data_out = {len_q, dest_q};
         S_PLD:   bus.data_out = mem[cnt];
         S_PAR:   bus.data_out = par_q ^ {7'b0, corrupt_q};
         default: bus.data_out = '0;
      endcase
   end

   assign bus.pkt_valid = (state == S_HDR) || (state == S_PLD);
   assign bus.in_ready  = (state == S_FILL);
   assign bus.tx_active = (state != S_IDLE);
   assign bus.tx_done   = tx_done_q;
   assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed and randomized packets
// compared against a byte-stream reference model.
module tb_router_pkt_tx;
   localparam int unsigned GAP_CYC = 3;
   localparam int unsigned BUDGET  = 2000;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   router_pkt_tx_if bus();

   router_pkt_tx #(.GAP(GAP_CYC)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   always #5 clock = ~clock;

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [7:0]  pay [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.start    = 1'b0;
      bus.dest     = '0;
      bus.len      = '0;
      bus.corrupt  = 1'b0;
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.busy     = 1'b0;
   endtask

   task automatic do_start(input logic [1:0] d, input logic [5:0] l, input logic c);
      bus.start   = 1'b1;
      bus.dest    = d;
      bus.len     = l;
      bus.corrupt = c;
      @(posedge clock);
      @(negedge clock);
      bus.start   = 1'b0;
   endtask

   // vmode: 0 = in_valid always high, 1 = toggling from high, 2 = random
   task automatic fill(input int unsigned l, input int unsigned vmode);
      int unsigned idx = 0;
      int unsigned cyc = 0;
      bit tog = 1'b1;
      chk("fill_ready_first", bus.in_ready, 1);
      chk("fill_active", bus.tx_active, 1);
      while (idx < l) begin
         if (cyc > BUDGET) begin
            chk("fill_timeout", 0, 1);
            return;
         end
         case (vmode)
            0:       bus.in_valid = 1'b1;
            1:       begin bus.in_valid = tog; tog = ~tog; end
            default: bus.in_valid = 1'($urandom_range(0, 1));
         endcase
         bus.in_data = bus.in_valid ? pay[idx] : 8'($urandom);
         bus.start   = 1'($urandom_range(0, 1));
         bus.dest    = 2'($urandom);
         bus.len     = 6'($urandom);
         bus.corrupt = 1'($urandom);
         @(posedge clock);
         if (bus.in_valid) idx++;
         cyc++;
         @(negedge clock);
         chk("fill_cfg_err", bus.cfg_err, 0);
         if (idx < l) begin
            chk("fill_ready", bus.in_ready, 1);
            chk("fill_pkt_valid", bus.pkt_valid, 0);
            chk("fill_data_out", bus.data_out, 0);
         end
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
   endtask

   // bmode: 0 = never busy, 1 = random busy, 2 = busy for 4 cycles on the second payload byte
   task automatic transmit(input logic [1:0] d, input logic [5:0] l, input logic c,
                           input int unsigned bmode);
      logic [7:0]  stream [$];
      logic [7:0]  p;
      int unsigned pos  = 0;
      int unsigned held = 0;
      int unsigned cyc  = 0;
      stream.push_back({l, d});
      for (int i = 0; i < int'(l); i++) stream.push_back(pay[i]);
      p = '0;
      foreach (stream[i]) p = p ^ stream[i];
      p[0] = p[0] ^ c;
      stream.push_back(p);
      while (pos < int'(l) + 2) begin
         if (cyc > BUDGET) begin
            chk("tx_timeout", 0, 1);
            return;
         end
         chk("tx_pkt_valid", bus.pkt_valid, (pos <= int'(l)) ? 1 : 0);
         chk("tx_data_out", bus.data_out, stream[pos]);
         chk("tx_active", bus.tx_active, 1);
         chk("tx_in_ready", bus.in_ready, 0);
         chk("tx_cfg_err", bus.cfg_err, 0);
         if (pos == 2) held++;
         case (bmode)
            0:       bus.busy = 1'b0;
            1:       bus.busy = ($urandom_range(0, 2) == 0);
            default: bus.busy = (pos == 2) && (held <= 4);
         endcase
         bus.start = 1'($urandom_range(0, 1));
         bus.dest  = 2'($urandom);
         bus.len   = 6'($urandom);
         @(posedge clock);
         if (!bus.busy) pos++;
         cyc++;
         @(negedge clock);
      end
      bus.busy  = 1'b0;
      bus.start = 1'b0;
      if (bmode == 2) chk("hold_cycles", held, 5);
      for (int g = 0; g < int'(GAP_CYC); g++) begin
         chk("gap_pkt_valid", bus.pkt_valid, 0);
         chk("gap_data_out", bus.data_out, 0);
         chk("gap_active", bus.tx_active, 1);
         chk("gap_tx_done", bus.tx_done, 0);
         @(negedge clock);
      end
      chk("done_pulse", bus.tx_done, 1);
      chk("done_active", bus.tx_active, 0);
      @(negedge clock);
      chk("done_clear", bus.tx_done, 0);
   endtask

   task automatic send(input logic [1:0] d, input logic [5:0] l, input logic c,
                       input int unsigned vmode, input int unsigned bmode);
      do_start(d, l, c);
      fill(l, vmode);
      transmit(d, l, c, bmode);
   endtask

   task automatic cfg_reject(input logic [1:0] d, input logic [5:0] l);
      do_start(d, l, 1'b0);
      chk("rej_cfg_err", bus.cfg_err, 1);
      chk("rej_in_ready", bus.in_ready, 0);
      chk("rej_pkt_valid", bus.pkt_valid, 0);
      chk("rej_active", bus.tx_active, 0);
      @(negedge clock);
      chk("rej_cfg_err_clear", bus.cfg_err, 0);
      chk("rej_in_ready_later", bus.in_ready, 0);
   endtask

   initial begin
      idle_inputs();
      resetn = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset_outputs",
          {bus.tx_active, bus.in_ready, bus.pkt_valid, bus.tx_done, bus.cfg_err, bus.data_out}, 0);
      resetn = 1'b1;
      @(negedge clock);

      // Basic packet, then the same packet with a stall on the second payload byte
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      send(2'd1, 6'd3, 1'b0, 0, 0);
      send(2'd1, 6'd3, 1'b0, 0, 2);

      // Rejected starts
      cfg_reject(2'd3, 6'd5);
      cfg_reject(2'd0, 6'd0);
      cfg_reject(2'd3, 6'd0);

      // Corrupted parity
      send(2'd1, 6'd3, 1'b1, 0, 0);

      // Maximum length with toggling in_valid
      for (int i = 0; i < 63; i++) pay[i] = 8'($urandom);
      send(2'd2, 6'd63, 1'b0, 1, 0);

      // Randomized packets with random fill gaps and router stalls
      for (int n = 0; n < 6; n++) begin
         logic [1:0] d;
         logic [5:0] l;
         d = 2'($urandom_range(0, 2));
         l = 6'($urandom_range(1, 63));
         for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
         send(d, l, 1'($urandom), 2, 1);
      end

      // Reset in the middle of the payload
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      do_start(2'd0, 6'd8, 1'b0);
      fill(8, 0);
      @(negedge clock);
      @(negedge clock);
      chk("pre_reset_pkt_valid", bus.pkt_valid, 1);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_pkt_valid", bus.pkt_valid, 0);
      chk("async_rst_active", bus.tx_active, 0);
      chk("async_rst_data_out", bus.data_out, 0);
      chk("async_rst_in_ready", bus.in_ready, 0);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      send(2'd2, 6'd5, 1'b0, 2, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
